// File: rtl/fir_tap_sequencer_mac.sv
// Tap sequencer and multiply-accumulate engine for one 64-tap FIR band.
// Shifts the sample delay line, sweeps the tap index, and emits a rounded, saturated Q1.15 result.
module fir_tap_sequencer_mac #(
  parameter int NUM_TAPS = 64,
  parameter int COUNT_W  = 6,
  parameter int DATA_W   = 16,
  parameter int GUARD_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sample_valid,
  output logic               o_ready,
  output logic               o_shift,
  output logic [COUNT_W-1:0] o_current_count,
  input  logic [DATA_W-1:0]  i_tap_sample,
  input  logic [DATA_W-1:0]  i_coeff,
  output logic [DATA_W-1:0]  o_sample,
  output logic               o_valid,
  output logic               o_overrun
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + GUARD_W;
  localparam int HI_W   = ACC_W - DATA_W + 1;
  localparam logic [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (DATA_W - 2);
  localparam logic [COUNT_W-1:0] LAST_TAP = COUNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MAC   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic                       accept;
  logic                       shift_next;
  logic                       last_tap;
  logic [COUNT_W-1:0]         count;
  logic [COUNT_W-1:0]         count_next;
  logic signed [PROD_W-1:0]   prod;
  logic                       prod_valid;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    final_sum;
  logic signed [ACC_W-1:0]    rounded;
  logic [HI_W-1:0]            rounded_hi;
  logic                       sat_over;
  logic [DATA_W-1:0]          sat_value;

  assign accept          = i_sample_valid && (state == IDLE);
  assign last_tap        = (count == LAST_TAP);
  assign o_current_count = count;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = LOAD;
      LOAD:                  state_next = MAC;
      MAC:     if (last_tap) state_next = DRAIN;
      DRAIN:                 state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    o_ready    = 1'b0;
    shift_next = 1'b0;
    count_next = '0;
    case (state)
      IDLE: begin
        o_ready    = 1'b1;
        shift_next = accept;
      end
      MAC:     count_next = count + 1'b1;
      default: count_next = '0;
    endcase
  end

  // Sequencer registers: shift strobe, tap index, overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_shift   <= 1'b0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_shift <= shift_next;
      count   <= count_next;
      if (i_sample_valid && (state != IDLE)) begin
        o_overrun <= 1'b1;
      end
    end
  end

  // Product pipeline: one product per MAC cycle, accumulated on the following edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      if (state == MAC) begin
        prod       <= $signed(i_tap_sample) * $signed(i_coeff);
        prod_valid <= 1'b1;
      end else begin
        prod_valid <= 1'b0;
      end
    end
  end

  assign prod_ext  = {{GUARD_W{prod[PROD_W-1]}}, prod};
  assign final_sum = acc + prod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else if (prod_valid) begin
      acc <= final_sum;
    end
  end

  // Round half up at bit 14, then clamp when the upper bits are not a pure sign extension
  assign rounded    = $signed(final_sum + RND_HALF) >>> (DATA_W - 1);
  assign rounded_hi = rounded[ACC_W-1:DATA_W-1];
  assign sat_over   = !((&rounded_hi) || !(|rounded_hi));

  always_comb begin
    sat_value = rounded[DATA_W-1:0];
    if (sat_over) begin
      sat_value = rounded[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= (state == DRAIN);
      if (state == DRAIN) begin
        o_sample <= sat_value;
      end
    end
  end

endmodule

// File: doc/fir_tap_sequencer_mac.md
Name: fir_tap_sequencer_mac

Overview:
- Read-side controller and multiply-accumulate engine for one equalizer band's 64-tap FIR.
- Accepts a new-sample request and issues the one-cycle shift strobe to the band's sample delay line.
- Sweeps the tap index 0..63 that selects both the delay-line mux output and the coefficient.
- Accumulates the 64 products and emits one rounded, saturated Q1.15 output sample with a valid pulse.

Parameters:
NUM_TAPS, 64, taps per sample; must equal 2**COUNT_W
COUNT_W, 6, tap index width
DATA_W, 16, sample and coefficient width (signed Q1.15)
GUARD_W, 6, accumulator guard bits (log2 NUM_TAPS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_sample_valid  in  1  new input sample present on delay-line input this cycle
o_ready  out  1  high only in IDLE; request accepted when i_sample_valid & o_ready
o_shift  out  1  one-cycle strobe to delay line; line shifts on edge where o_shift=1
o_current_count  out  COUNT_W  tap index driving delay-line mux and coefficient table
i_tap_sample  in  DATA_W  signed delay-line mux output for o_current_count (combinational)
i_coeff  in  DATA_W  signed coefficient for o_current_count (combinational)
o_sample  out  DATA_W  signed Q1.15 filter output, held until next result
o_valid  out  1  one-cycle pulse, o_sample updated
o_overrun  out  1  sticky: i_sample_valid seen while not IDLE

Behaviour:
- Reset: state IDLE, o_shift=0, o_current_count=0, o_sample=0, o_valid=0, o_overrun=0, accumulator=0, product register=0, prod_valid=0. Reset mid-sweep aborts, no o_valid.
- States IDLE -> LOAD -> MAC -> DRAIN -> IDLE.
- IDLE: o_ready=1, count held 0. At edge E0 with i_sample_valid=1: -> LOAD, accumulator cleared.
- LOAD (one cycle): o_shift=1 (registered). At E1 -> MAC, count=0.
- MAC: each edge captures product = i_tap_sample * i_coeff (full 2*DATA_W signed, Q2.30) into product register, sets prod_valid, increments count. Count 0..63; at the edge capturing count 63, count wraps to 0 and state -> DRAIN.
- Accumulate: every edge with prod_valid=1, acc <= acc + sign-extended product. Accumulator width 2*DATA_W+GUARD_W (38), Q8.30; never overflows for 64 taps.
- DRAIN (one cycle, E66): final = acc + last product (combinational); result = (final + 2**14) >>> 15 (round half up, arithmetic shift); saturate to [-32768, 32767]; register into o_sample; o_valid=1 for the following cycle; -> IDLE; prod_valid cleared.
- Latency: o_valid high in the cycle after E66, i.e. 66 clocks after the accepting edge E0. Back-to-back throughput: one sample per 67 cycles (a new request is accepted at E67, the same edge on which o_valid drops).
- i_sample_valid while state != IDLE: ignored, o_overrun <= 1 and stays set until rst.
- i_sample_valid in IDLE on the same edge that o_valid drops: accepted normally.
- o_sample holds its value between results. o_valid and o_shift are never high for more than one cycle.

Test Plan:
- Rounding: bench delay-line model; coeff[0]=0x0001, all other coeffs 0, sample 0x4000 at delay 0. Required: o_sample=0x0001 (product 2**14 rounds up); o_valid exactly 66 cycles after acceptance; o_shift one pulse, one cycle after acceptance.
- Single tap: coeff[5]=0x4000, others 0; line holds 0x2000 at delay 5, zeros elsewhere -> o_sample=0x1000. Verify o_current_count sweeps 0..63 consecutively, then returns to 0.
- Positive saturation: all coeffs 0x4000, all samples 0x4000 (sum 16.0) -> o_sample=0x7FFF. Negative saturation: samples 0x8000, coeffs 0x4000 -> 0x8000.
- Full-scale negative product: coeff[0]=0x8000, sample 0x8000, others 0 -> +1.0 saturates to 0x7FFF.
- Back-to-back and overrun: pulse i_sample_valid at cycles 0 and 10 -> second ignored, o_overrun=1, single o_valid. Re-assert i_sample_valid on the cycle o_valid drops -> accepted, second result correct.
- Reset mid-MAC: assert rst at count 30 -> all outputs return to reset values at once, no o_valid. Next request after release produces a correct result with no stale accumulation.
